// File: rtl/tpm_arbiter.sv
// Triple-port view of one 1RW+1R SRAM: round-robin grants of up to one write and two reads per cycle.
// Pin outputs and response strobes are registered; read data returns two cycles after acceptance.
module tpm_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              req_valid,
   input  logic [2:0]              req_we,
   input  logic [3*ADDR_WIDTH-1:0] req_addr,
   input  logic [3*DATA_WIDTH-1:0] req_wdata,
   output logic [2:0]              req_ready,
   output logic [2:0]              rsp_valid,
   output logic [3*DATA_WIDTH-1:0] rsp_rdata,
   output logic                    sram_csb0,
   output logic                    sram_web0,
   output logic                    sram_wmask0,
   output logic [ADDR_WIDTH-1:0]   sram_addr0,
   output logic [DATA_WIDTH-1:0]   sram_din0,
   input  logic [DATA_WIDTH-1:0]   sram_dout0,
   output logic                    sram_csb1,
   output logic [ADDR_WIDTH-1:0]   sram_addr1,
   input  logic [DATA_WIDTH-1:0]   sram_dout1,
   output logic [CNT_WIDTH-1:0]    stall_cnt
);
   logic [1:0]            rr_ptr;
   logic                  p0_use, p0_we, p1_use, any_stall;
   logic [1:0]            p0_id, p1_id, first_stall;
   logic [ADDR_WIDTH-1:0] p0_addr, p1_addr;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic [1:0]            s1_valid, s2_valid;   // indexed by SRAM port
   logic [1:0][1:0]       s1_id, s2_id;

   assign sram_wmask0 = 1'b1;

   function automatic logic [1:0] visit(input logic [1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= 3) s = s - 3;
      return 2'(s);
   endfunction

   always_comb begin
      logic [1:0]            idx;
      logic [ADDR_WIDTH-1:0] a;
      // NOTE: every signal gets a default before the loop so no path can infer a latch.
      idx         = '0;
      a           = '0;
      req_ready   = '0;
      p0_use      = 1'b0;
      p0_we       = 1'b0;
      p1_use      = 1'b0;
      p0_id       = '0;
      p1_id       = '0;
      p0_addr     = '0;
      p1_addr     = '0;
      p0_wdata    = '0;
      any_stall   = 1'b0;
      first_stall = '0;
      for (int k = 0; k < 3; k++) begin
         idx = visit(rr_ptr, k);
         a   = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
         if (req_valid[idx]) begin
            if (req_we[idx]) begin
               // A write needs port 0 and must not collide with a read already granted on port 1.
               if (!p0_use && !(p1_use && p1_addr == a)) begin
                  req_ready[idx] = 1'b1;
                  p0_use         = 1'b1;
                  p0_we          = 1'b1;
                  p0_id          = idx;
                  p0_addr        = a;
                  p0_wdata       = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
               end else begin
                  if (!any_stall) first_stall = idx;
                  any_stall = 1'b1;
               end
            end else if (p0_use && p0_we && p0_addr == a) begin
               if (!any_stall) first_stall = idx;
               any_stall = 1'b1;
            end else if (!p1_use) begin
               req_ready[idx] = 1'b1;
               p1_use         = 1'b1;
               p1_id          = idx;
               p1_addr        = a;
            end else if (!p0_use) begin
               req_ready[idx] = 1'b1;
               p0_use         = 1'b1;
               p0_id          = idx;
               p0_addr        = a;
            end else begin
               if (!any_stall) first_stall = idx;
               any_stall = 1'b1;
            end
         end
      end
   end

   // NOTE: only the control and pipeline state is reset; the SRAM array keeps its contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_csb0  <= 1'b1;
         sram_web0  <= 1'b1;
         sram_addr0 <= '0;
         sram_din0  <= '0;
         sram_csb1  <= 1'b1;
         sram_addr1 <= '0;
         s1_valid   <= '0;
         s1_id      <= '0;
         s2_valid   <= '0;
         s2_id      <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rr_ptr     <= '0;
         stall_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         sram_csb0 <= ~p0_use;
         sram_web0 <= ~(p0_use & p0_we);
         if (p0_use) begin
            sram_addr0 <= p0_addr;
            if (p0_we) sram_din0 <= p0_wdata;
         end
         sram_csb1 <= ~p1_use;
         if (p1_use) sram_addr1 <= p1_addr;

         s1_valid <= {p1_use, p0_use & ~p0_we};
         s1_id    <= {p1_id, p0_id};
         s2_valid <= s1_valid;
         s2_id    <= s1_id;

         rsp_valid <= '0;
         for (int p = 0; p < 2; p++) begin
            if (s2_valid[p]) begin
               rsp_valid[s2_id[p]] <= 1'b1;
               rsp_rdata[s2_id[p]*DATA_WIDTH +: DATA_WIDTH] <= (p == 0) ? sram_dout0 : sram_dout1;
            end
         end

         if (any_stall) begin
            rr_ptr <= first_stall;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_tpm_arbiter.sv
// Bench for tpm_arbiter: behavioural SRAM, port-count grant model and a pending-response scoreboard.
module tb_tpm_arbiter;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [2:0]      req_valid = '0;
   logic [2:0]      req_we = '0;
   logic [3*AW-1:0] req_addr = '0;
   logic [3*DW-1:0] req_wdata = '0;
   logic [2:0]      req_ready, rsp_valid;
   logic [3*DW-1:0] rsp_rdata;
   logic            sram_csb0, sram_web0, sram_wmask0, sram_csb1;
   logic [AW-1:0]   sram_addr0, sram_addr1;
   logic [DW-1:0]   sram_din0, sram_dout0, sram_dout1;
   logic [CW-1:0]   stall_cnt;

   tpm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // SRAM macro: pins sampled at posedge, read data valid before the following edge.
   logic [DW-1:0] sram_mem [1024];
   bit            loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int a = 0; a < 1024; a++) sram_mem[a] <= DW'(a * 17);
         loaded <= 1'b1;
      end else begin
         if (!sram_csb0) begin
            if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= sram_mem[sram_addr0];
         end
         if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
      end
   end

   typedef struct {
      int            id;
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   logic [DW-1:0] ref_mem [1024];
   exp_t          pend[$];
   int            m_rr, m_stall, edge_n;
   int            n_pass = 0, n_total = 0, n_fail = 0;
   int            rsp_count [3];
   int            wait_run [3];
   int            max_wait;
   logic [2:0]    last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_valid[i]           = v;
      req_we[i]              = we;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   // Port budget: at most one write, at most two accesses in total, no same-address write/read pair.
   function automatic void model_grant(output logic [2:0] rdy, output int first);
      int            n_rd, n_wr;
      logic [AW-1:0] rd_a, wr_a;
      rdy = '0; first = -1; n_rd = 0; n_wr = 0; rd_a = '0; wr_a = '0;
      for (int k = 0; k < 3; k++) begin
         int            i;
         logic [AW-1:0] a;
         bit            ok;
         i = (m_rr + k) % 3;
         a = req_addr[i*AW +: AW];
         if (req_valid[i]) begin
            if (req_we[i]) ok = (n_wr == 0) && (n_rd < 2) && !(n_rd == 1 && rd_a == a);
            else           ok = (n_rd + n_wr < 2) && !(n_wr == 1 && wr_a == a);
            if (ok) begin
               rdy[i] = 1'b1;
               if (req_we[i]) begin n_wr++; wr_a = a; end
               else begin
                  if (n_rd == 0) rd_a = a;
                  n_rd++;
               end
            end else if (first < 0) first = i;
         end
      end
   endfunction

   // Called right after a negedge with inputs already driven; returns at the next negedge.
   task automatic do_cycle();
      logic [2:0]    rdy;
      int            first;
      logic [2:0]    exp_v;
      logic [DW-1:0] exp_d [3];
      #1;
      model_grant(rdy, first);
      check("req_ready", 32'(req_ready), 32'(rdy));
      for (int i = 0; i < 3; i++) begin
         if (req_valid[i] && !req_ready[i]) begin
            wait_run[i]++;
            if (wait_run[i] > max_wait) max_wait = wait_run[i];
         end else wait_run[i] = 0;
      end
      last_acc = req_valid & req_ready;
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 3; i++) begin
         if (req_valid[i] && rdy[i]) begin
            if (req_we[i]) ref_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
            else pend.push_back('{id: i, due: edge_n + 2, data: ref_mem[req_addr[i*AW +: AW]]});
         end
      end
      if (first >= 0) begin
         m_rr = first;
         if (m_stall != 65535) m_stall++;
      end
      #1;
      exp_v = '0;
      for (int i = 0; i < 3; i++) exp_d[i] = '0;
      while (pend.size() > 0 && pend[0].due == edge_n) begin
         exp_v[pend[0].id] = 1'b1;
         exp_d[pend[0].id] = pend[0].data;
         void'(pend.pop_front());
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(exp_v[i]));
         if (exp_v[i]) check($sformatf("rsp_rdata[%0d]", i), 32'(rsp_rdata[i*DW +: DW]), 32'(exp_d[i]));
         if (rsp_valid[i]) rsp_count[i]++;
      end
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0;
      #2 rst = 1'b1;
      #1;
      check("rst csb0", 32'(sram_csb0), 32'd1);
      check("rst csb1", 32'(sram_csb1), 32'd1);
      check("rst web0", 32'(sram_web0), 32'd1);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst stall_cnt", 32'(stall_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pend.delete();
      m_rr = 0;
      m_stall = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 1024; a++) ref_mem[a] = DW'(a * 17);
      m_rr = 0; m_stall = 0; edge_n = 0; max_wait = 0; last_acc = '0;
      for (int i = 0; i < 3; i++) begin rsp_count[i] = 0; wait_run[i] = 0; end

      // Power-on reset, asserted before the first clock edge.
      #1 rst = 1'b1;
      #1;
      check("init csb0", 32'(sram_csb0), 32'd1);
      check("init csb1", 32'(sram_csb1), 32'd1);
      check("init web0", 32'(sram_web0), 32'd1);
      check("init addr0", 32'(sram_addr0), 32'd0);
      check("init addr1", 32'(sram_addr1), 32'd0);
      check("init din0", 32'(sram_din0), 32'd0);
      check("init rsp_valid", 32'(rsp_valid), 32'd0);
      check("init rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("init stall_cnt", 32'(stall_cnt), 32'd0);
      check("init wmask0", 32'(sram_wmask0), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset while two reads are in flight: they must never respond.
      set_req(0, 1'b1, 1'b0, 10'h005, '0);
      set_req(1, 1'b1, 1'b0, 10'h006, '0);
      do_cycle();
      check("midread csb0", 32'(sram_csb0), 32'd0);
      check("midread csb1", 32'(sram_csb1), 32'd0);
      do_reset();
      repeat (4) do_cycle();

      // Write then read of the same address on the next cycle.
      set_req(0, 1'b1, 1'b1, 10'h012, 8'hA5);
      do_cycle();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b1, 1'b0, 10'h012, '0);
      do_cycle();
      req_valid = '0;
      repeat (2) do_cycle();
      check("raw rsp_valid1", 32'(rsp_valid[1]), 32'd1);
      check("raw rsp_rdata1", 32'(rsp_rdata[1*DW +: DW]), 32'hA5);

      // Three reads in one cycle from rr_ptr = 0.
      do_reset();
      set_req(0, 1'b1, 1'b0, 10'h001, '0);
      set_req(1, 1'b1, 1'b0, 10'h002, '0);
      set_req(2, 1'b1, 1'b0, 10'h003, '0);
      #1 check("3rd ready", 32'(req_ready), 32'b011);
      do_cycle();
      check("3rd port1 addr", 32'(sram_addr1), 32'h001);
      check("3rd port0 addr", 32'(sram_addr0), 32'h002);
      req_valid[1:0] = 2'b00;
      #1 check("3rd ready next", 32'(req_ready), 32'b100);
      do_cycle();
      check("3rd stall_cnt", 32'(stall_cnt), 32'd1);
      req_valid = '0;
      do_cycle();
      check("3rd data0", 32'(rsp_rdata[0*DW +: DW]), 32'h11);
      check("3rd data1", 32'(rsp_rdata[1*DW +: DW]), 32'h22);
      do_cycle();
      check("3rd data2", 32'(rsp_rdata[2*DW +: DW]), 32'h33);

      // Two writes in one cycle, then read both back.
      do_reset();
      set_req(0, 1'b1, 1'b1, 10'h020, 8'h5A);
      set_req(1, 1'b1, 1'b1, 10'h021, 8'h6B);
      #1 check("2wr ready", 32'(req_ready), 32'b001);
      do_cycle();
      req_valid[0] = 1'b0;
      #1 check("2wr ready next", 32'(req_ready), 32'b010);
      do_cycle();
      req_valid = '0;
      do_cycle();
      set_req(0, 1'b1, 1'b0, 10'h021, '0);
      set_req(2, 1'b1, 1'b0, 10'h020, '0);
      do_cycle();
      req_valid = '0;
      repeat (2) do_cycle();

      // Same-address write and read in one cycle: the read waits one cycle.
      do_reset();
      set_req(0, 1'b1, 1'b1, 10'h040, 8'h3C);
      set_req(1, 1'b1, 1'b0, 10'h040, '0);
      #1 check("haz ready", 32'(req_ready), 32'b001);
      do_cycle();
      req_valid[0] = 1'b0;
      #1 check("haz ready next", 32'(req_ready), 32'b010);
      do_cycle();
      req_valid = '0;
      repeat (2) do_cycle();
      check("haz rsp_valid1", 32'(rsp_valid[1]), 32'd1);
      check("haz rsp_rdata1", 32'(rsp_rdata[1*DW +: DW]), 32'h3C);

      // Fairness: three requesters reading continuously for 30 cycles.
      do_reset();
      for (int i = 0; i < 3; i++) begin rsp_count[i] = 0; wait_run[i] = 0; end
      max_wait = 0;
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < 3; i++)
            if (c == 0 || last_acc[i]) set_req(i, 1'b1, 1'b0, AW'(10'h100 + $urandom_range(255, 0)), '0);
         do_cycle();
      end
      req_valid = '0;
      repeat (3) do_cycle();
      for (int i = 0; i < 3; i++) check($sformatf("fair count[%0d]", i), 32'(rsp_count[i]), 32'd20);
      check("fair max_wait<=1", 32'(max_wait <= 1), 32'd1);

      // Random mix over a narrow address window to provoke hazards.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++)
            set_req(i, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    AW'($urandom_range(16'h47, 16'h40)), DW'($urandom));
         do_cycle();
      end
      req_valid = '0;
      repeat (3) do_cycle();
      check("drain pending", 32'(pend.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
